// File: rtl/adder_pkg.sv
// adder_pkg: shared defaults and chunk-geometry helpers for pipelined_adder.
package adder_pkg;
   localparam int WIDTH_DEF  = 32;
   localparam int STAGES_DEF = 4;
   function automatic bit stages_ok(input int width, input int stages);
      return stages >= 1 && width % stages == 0;
   endfunction
   function automatic int chunk_width(input int width, input int stages);
      return stages >= 1 ? width / stages : width;
   endfunction
endpackage

// File: rtl/pipelined_adder_if.sv
// pipelined_adder_if: operand and result streams of pipelined_adder.
// The sub signal exists only when ADDER_SUB_EN is defined.
interface pipelined_adder_if
   import adder_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF
);
   logic             s_valid;
   logic             s_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic             m_valid;
   logic             m_ready;
   logic [WIDTH-1:0] sum;
   logic             cout;
   logic             ovf;
`ifdef ADDER_SUB_EN
   logic             sub;
   modport master (output s_valid, a, b, cin, sub, m_ready, input s_ready, m_valid, sum, cout, ovf);
   modport slave (input s_valid, a, b, cin, sub, m_ready, output s_ready, m_valid, sum, cout, ovf);
`else
   modport master (output s_valid, a, b, cin, m_ready, input s_ready, m_valid, sum, cout, ovf);
   modport slave (input s_valid, a, b, cin, m_ready, output s_ready, m_valid, sum, cout, ovf);
`endif
endinterface

// File: rtl/full_adder.sv
// full_adder: single-bit full adder.
module full_adder (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic sum,
   output logic cout
);
   assign sum  = a ^ b ^ cin;
   assign cout = (a & b) | (cin & (a ^ b));
endmodule

// File: rtl/ripple_chunk.sv
// ripple_chunk: combinational CW-bit ripple of full adders.
module ripple_chunk #(
   parameter int CW = 8
) (
   input  logic [CW-1:0] a,
   input  logic [CW-1:0] b,
   input  logic          cin,
   output logic [CW-1:0] sum,
   output logic          cout
);
   logic [CW:0] c;
   assign c[0] = cin;
   for (genvar i = 0; i < CW; i++) begin : g_bit
      full_adder u_fa (.a(a[i]), .b(b[i]), .cin(c[i]), .sum(sum[i]), .cout(c[i+1]));
   end
   assign cout = c[CW];
endmodule

// File: rtl/pipelined_adder.sv
// pipelined_adder: valid/ready pipelined adder, one register stage per CW-bit chunk.
// Define ADDER_SUB_EN to add the sub port (sum = a - b when sub=1).
module pipelined_adder
   import adder_pkg::*;
#(
   parameter int WIDTH  = WIDTH_DEF,
   parameter int STAGES = STAGES_DEF
) (
   input logic              clk,
   input logic              rst,
   pipelined_adder_if.slave io
);
   localparam int CW = chunk_width(WIDTH, STAGES);
   if (!stages_ok(WIDTH, STAGES)) begin : g_bad_cfg
      $error("pipelined_adder: STAGES must be >= 1 and divide WIDTH");
   end
   logic              en;
   logic              c0;
   logic              ov;
   logic [WIDTH-1:0]  bp;
   logic [WIDTH-1:0]  sum_w;
   logic [STAGES-1:0] v_q;
   logic [STAGES-1:0] cr;
`ifdef ADDER_SUB_EN
   assign bp = io.sub ? ~io.b : io.b;
   assign c0 = io.sub | io.cin;
`else
   assign bp = io.b;
   assign c0 = io.cin;
`endif
   assign en         = io.m_ready | ~io.m_valid;
   assign io.s_ready = en;
   assign io.m_valid = v_q[STAGES-1];
   assign io.sum     = sum_w;
   assign io.cout    = cr[STAGES-1];
   assign io.ovf     = ov;
   always_ff @(posedge clk)
      if (rst) v_q <= '0;
      else if (en) v_q <= (v_q << 1) | STAGES'(io.s_valid);
   // Chunk j is skewed j cycles in, then de-skewed STAGES-j cycles out: every chunk sees STAGES registers.
   for (genvar j = 0; j < STAGES; j++) begin : g_stage
      logic [CW-1:0] ak;
      logic [CW-1:0] bk;
      logic [CW-1:0] s;
      logic          ci;
      logic          co;
      logic          c_q;
      logic [CW-1:0] sd [STAGES-j];
      if (j == 0) begin : g_head
         assign ak = io.a[j*CW +: CW];
         assign bk = bp[j*CW +: CW];
         assign ci = c0;
      end else begin : g_skew
         logic [CW-1:0] ad [j];
         logic [CW-1:0] bd [j];
         always_ff @(posedge clk)
            if (en) begin
               ad[0] <= io.a[j*CW +: CW];
               bd[0] <= bp[j*CW +: CW];
               for (int i = 1; i < j; i++) begin
                  ad[i] <= ad[i-1];
                  bd[i] <= bd[i-1];
               end
            end
         assign ak = ad[j-1];
         assign bk = bd[j-1];
         assign ci = cr[j-1];
      end
      ripple_chunk #(.CW(CW)) u_chunk (.a(ak), .b(bk), .cin(ci), .sum(s), .cout(co));
      always_ff @(posedge clk)
         if (rst) begin
            c_q <= 1'b0;
            for (int i = 0; i < STAGES - j; i++) sd[i] <= '0;
         end else if (en) begin
            c_q   <= co;
            sd[0] <= s;
            for (int i = 1; i < STAGES - j; i++) sd[i] <= sd[i-1];
         end
      assign cr[j] = c_q;
      assign sum_w[j*CW +: CW] = sd[STAGES-j-1];
      if (j == STAGES - 1) begin : g_tail
         always_ff @(posedge clk)
            if (rst) ov <= 1'b0;
            else if (en) ov <= (ak[CW-1] == bk[CW-1]) & (s[CW-1] != ak[CW-1]);
      end
   end
endmodule
